lfo_ctrl: RTL and testbench

Sequencer that sits between the audio sample FIFO and the LFO generator. It turns per-sample requests into single-cycle LFO update strobes. It applies frequency changes only between updates and ramps depth one step at a time to avoid zipper noise. It then presents the resulting modulation value to the downstream delay-address calculator over a valid/ready handshake.

---
 rtl/lfo_ctrl.sv | 137 +++++++++++++
 tb/tb_lfo_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lfo_ctrl.sv
// rtl/lfo_ctrl.sv - sequences per-sample LFO update strobes, depth ramp and modulation handoff
// One request in flight plus a depth-1 pending slot; extra requests raise a sticky overrun.
module lfo_ctrl #(
  parameter int RAMP_DIV = 256,
  parameter int SETTLE   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               sampleReq_i,
  input  logic [3:0]         freqReq_i,
  input  logic [3:0]         depthReq_i,
  input  logic signed [15:0] lfoWave_i,
  input  logic               lfoNewVal_i,
  output logic               lfoUpdate_o,
  output logic [3:0]         freqSetting_o,
  output logic [3:0]         scaleFactor_o,
  output logic signed [15:0] mod_o,
  output logic               modValid_o,
  input  logic               modReady_i,
  output logic               busy_o,
  output logic               overrun_o
);

  localparam int RCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_SETTLE, S_PRESENT} state_t;

  state_t             state_q, state_d;
  logic               pend_q, pend_d;
  logic [RCW-1:0]     ramp_cnt_q, ramp_cnt_d;
  logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
  logic               upd_q, upd_d;
  logic [3:0]         freq_q, freq_d;
  logic [3:0]         scale_q, scale_d;
  logic signed [15:0] mod_q, mod_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    ramp_cnt_d   = ramp_cnt_q;
    settle_cnt_d = settle_cnt_q;
    upd_d        = 1'b0;
    freq_d       = freq_q;
    scale_d      = scale_q;
    mod_d        = mod_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;

    // Requests arriving while busy park in the single pending slot.
    if (state_q != S_IDLE && sampleReq_i) begin
      if (pend_q) ovr_d = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sampleReq_i || pend_q) begin
          state_d = S_STEP;
          upd_d   = 1'b1;
          freq_d  = freqReq_i;
          pend_d  = sampleReq_i && pend_q;
        end
      end
      S_STEP: begin
        state_d      = S_SETTLE;
        settle_cnt_d = SCW'(SETTLE - 1);
      end
      S_SETTLE: begin
        if (lfoNewVal_i) mod_d = lfoWave_i;
        if (settle_cnt_q == '0) begin
          state_d = S_PRESENT;
          valid_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q - SCW'(1);
        end
      end
      S_PRESENT: begin
        if (valid_q && modReady_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          // Depth moves one step per RAMP_DIV accepted samples to avoid zipper noise.
          if (ramp_cnt_q == RCW'(RAMP_DIV - 1)) begin
            ramp_cnt_d = '0;
            if (scale_q < depthReq_i)      scale_d = scale_q + 4'd1;
            else if (scale_q > depthReq_i) scale_d = scale_q - 4'd1;
          end else begin
            ramp_cnt_d = ramp_cnt_q + RCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      ramp_cnt_q   <= '0;
      settle_cnt_q <= '0;
      upd_q        <= 1'b0;
      freq_q       <= 4'd0;
      scale_q      <= 4'd0;
      mod_q        <= 16'sd0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      ramp_cnt_q   <= ramp_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      upd_q        <= upd_d;
      freq_q       <= freq_d;
      scale_q      <= scale_d;
      mod_q        <= mod_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
    end
  end

  assign lfoUpdate_o   = upd_q;
  assign freqSetting_o = freq_q;
  assign scaleFactor_o = scale_q;
  assign mod_o         = mod_q;
  assign modValid_o    = valid_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_lfo_ctrl.sv
// tb/tb_lfo_ctrl.sv - directed self-checking bench for lfo_ctrl
module tb_lfo_ctrl;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               sampleReq_i;
  logic [3:0]         freqReq_i;
  logic [3:0]         depthReq_i;
  logic signed [15:0] lfoWave_i;
  logic               lfoNewVal_i;
  logic               lfoUpdate_o;
  logic [3:0]         freqSetting_o;
  logic [3:0]         scaleFactor_o;
  logic signed [15:0] mod_o;
  logic               modValid_o;
  logic               modReady_i;
  logic               busy_o;
  logic               overrun_o;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int u0;

  lfo_ctrl #(.RAMP_DIV(2), .SETTLE(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .sampleReq_i(sampleReq_i),
    .freqReq_i(freqReq_i), .depthReq_i(depthReq_i), .lfoWave_i(lfoWave_i),
    .lfoNewVal_i(lfoNewVal_i), .lfoUpdate_o(lfoUpdate_o),
    .freqSetting_o(freqSetting_o), .scaleFactor_o(scaleFactor_o),
    .mod_o(mod_o), .modValid_o(modValid_o), .modReady_i(modReady_i),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (lfoUpdate_o) upd_cnt <= upd_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_upd"},   {31'd0, lfoUpdate_o},   32'd0);
    check_eq({tag, "_freq"},  {28'd0, freqSetting_o}, 32'd0);
    check_eq({tag, "_scale"}, {28'd0, scaleFactor_o}, 32'd0);
    check_eq({tag, "_mod"},   {16'd0, mod_o},         32'd0);
    check_eq({tag, "_valid"}, {31'd0, modValid_o},    32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy_o},        32'd0);
    check_eq({tag, "_ovr"},   {31'd0, overrun_o},     32'd0);
  endtask

  // One request with modReady_i high; request-to-valid must be exactly 5 ticks.
  task automatic do_txn(input string tag);
    int n;
    sampleReq_i = 1'b1;
    tick();
    sampleReq_i = 1'b0;
    n = 0;
    while (!modValid_o && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, n, 32'd5);
    tick();
  endtask

  initial begin
    reset_i = 1'b1; sampleReq_i = 1'b0; freqReq_i = 4'd0; depthReq_i = 4'd0;
    lfoWave_i = 16'sd0; lfoNewVal_i = 1'b0; modReady_i = 1'b0;
    tick(); tick();
    check_all_zero("rst");
    reset_i = 1'b0;
    tick();
    check_eq("post_rst_upd", {31'd0, lfoUpdate_o}, 32'd0);

    // Single request, capture in 2nd SETTLE cycle, immediate accept.
    modReady_i = 1'b1; lfoWave_i = 16'sh1234; freqReq_i = 4'd3;
    u0 = upd_cnt;
    sampleReq_i = 1'b1; tick(); sampleReq_i = 1'b0;
    check_eq("t1_upd", {31'd0, lfoUpdate_o}, 32'd1);
    check_eq("t1_freq", {28'd0, freqSetting_o}, 32'd3);
    check_eq("t1_busy", {31'd0, busy_o}, 32'd1);
    tick(); tick();
    check_eq("t1_upd_one", {31'd0, lfoUpdate_o}, 32'd0);
    lfoNewVal_i = 1'b1; tick(); lfoNewVal_i = 1'b0;
    freqReq_i = 4'd9; lfoWave_i = 16'sh7777;
    tick();
    check_eq("t1_valid_early", {31'd0, modValid_o}, 32'd0);
    check_eq("t1_freq_hold", {28'd0, freqSetting_o}, 32'd3);
    tick();
    check_eq("t1_valid", {31'd0, modValid_o}, 32'd1);
    check_eq("t1_mod", {16'd0, mod_o}, 32'h1234);
    tick();
    check_eq("t1_idle_valid", {31'd0, modValid_o}, 32'd0);
    check_eq("t1_idle_busy", {31'd0, busy_o}, 32'd0);
    check_eq("t1_freq_idle", {28'd0, freqSetting_o}, 32'd3);
    check_eq("t1_upd_count", upd_cnt - u0, 32'd1);

    // Back-to-back at minimum spacing: new freq applies, no capture keeps old mod, stall 20.
    modReady_i = 1'b0;
    sampleReq_i = 1'b1; tick(); sampleReq_i = 1'b0;
    check_eq("t2_upd", {31'd0, lfoUpdate_o}, 32'd1);
    check_eq("t2_freq", {28'd0, freqSetting_o}, 32'd9);
    repeat (5) tick();
    check_eq("t2_valid", {31'd0, modValid_o}, 32'd1);
    check_eq("t2_mod_kept", {16'd0, mod_o}, 32'h1234);
    for (int i = 0; i < 20; i++) begin
      lfoNewVal_i = i[0];
      lfoWave_i = 16'(i * 16'h0101);
      tick();
      check_eq("t2_hold", {15'd0, modValid_o, mod_o}, {15'd0, 1'b1, 16'h1234});
    end
    lfoNewVal_i = 1'b0;
    modReady_i = 1'b1;
    tick();
    check_eq("t2_xfer_valid", {31'd0, modValid_o}, 32'd0);
    check_eq("t2_xfer_busy", {31'd0, busy_o}, 32'd0);

    // Pending plus overrun.
    u0 = upd_cnt;
    sampleReq_i = 1'b1; tick(); sampleReq_i = 1'b0;
    tick();
    sampleReq_i = 1'b1; tick(); sampleReq_i = 1'b0;
    check_eq("t3_no_ovr", {31'd0, overrun_o}, 32'd0);
    tick();
    sampleReq_i = 1'b1; tick(); sampleReq_i = 1'b0;
    check_eq("t3_ovr", {31'd0, overrun_o}, 32'd1);
    tick();
    check_eq("t3_valid", {31'd0, modValid_o}, 32'd1);
    tick();
    check_eq("t3_gap_busy", {31'd0, busy_o}, 32'd0);
    check_eq("t3_gap_upd", {31'd0, lfoUpdate_o}, 32'd0);
    tick();
    check_eq("t3_restart_upd", {31'd0, lfoUpdate_o}, 32'd1);
    repeat (5) tick();
    check_eq("t3_valid2", {31'd0, modValid_o}, 32'd1);
    repeat (5) tick();
    check_eq("t3_done_busy", {31'd0, busy_o}, 32'd0);
    check_eq("t3_upd_count", upd_cnt - u0, 32'd2);
    check_eq("t3_ovr_sticky", {31'd0, overrun_o}, 32'd1);

    // Reset in PRESENT with a pending request parked.
    modReady_i = 1'b0;
    sampleReq_i = 1'b1; tick(); sampleReq_i = 1'b0;
    tick();
    sampleReq_i = 1'b1; tick(); sampleReq_i = 1'b0;
    repeat (3) tick();
    check_eq("t4_valid", {31'd0, modValid_o}, 32'd1);
    u0 = upd_cnt;
    reset_i = 1'b1; sampleReq_i = 1'b1;
    tick();
    check_all_zero("t4_rst");
    tick(); tick();
    check_eq("t4_rst_upd", upd_cnt - u0, 32'd0);
    reset_i = 1'b0; sampleReq_i = 1'b0;
    tick(); tick(); tick();
    check_eq("t4_after_busy", {31'd0, busy_o}, 32'd0);
    check_eq("t4_after_upd", upd_cnt - u0, 32'd0);

    // Depth ramp with RAMP_DIV = 2.
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    depthReq_i = 4'd15; modReady_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      do_txn("ramp_up");
      check_eq("ramp_up_scale", {28'd0, scaleFactor_o}, k / 2);
    end
    depthReq_i = 4'd12;
    for (int j = 1; j <= 6; j++) begin
      do_txn("ramp_dn");
      check_eq("ramp_dn_scale", {28'd0, scaleFactor_o}, 15 - j / 2);
    end
    repeat (2) do_txn("ramp_hold");
    check_eq("ramp_hold_scale", {28'd0, scaleFactor_o}, 32'd12);
    check_eq("ramp_no_ovr", {31'd0, overrun_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
